// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: front-end sequencer for the radix-2 SDF FFT chain.
// Optional frame counter enabled by defining FFT_FRAME_CNT_EN.
module fft_frame_ctrl #(
    parameter int LOG2N        = 7,
    parameter int GAP_CYCLES   = 70,
    parameter int MAX_INFLIGHT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_real,
    input  logic [31:0] s_img,
    output logic        start,
    output logic        over,
    output logic [31:0] data_in_real,
    output logic [31:0] data_in_img,
    input  logic        chain_end,
    output logic        busy,
    output logic [3:0]  inflight,
    output logic        err_underrun,
    output logic        err_spurious
`ifdef FFT_FRAME_CNT_EN
    ,
    input  logic        cnt_clr,
    output logic [15:0] frame_cnt
`endif
);

    localparam int N  = 1 << LOG2N;
    localparam int CW = (LOG2N > 0) ? LOG2N : 1;
    localparam logic [CW-1:0] LAST     = CW'(N - 1);
    localparam logic [7:0]    GAP_LAST = 8'(GAP_CYCLES - 1);
    localparam logic [3:0]    MAX_CRED = 4'(MAX_INFLIGHT);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        GAP
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [7:0]      gap_cnt;
    logic            accept;
    logic            issue_over;
    logic [3:0]      infl_nxt;
    logic            spurious;
    logic            rdy_nxt;

    assign accept = s_valid && s_ready;

    // Next state, over-issue and credit bookkeeping for the registered outputs.
    always_comb begin
        issue_over = 1'b0;
        state_nxt  = state;
        infl_nxt   = inflight;
        spurious   = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (N == 1) begin
                        issue_over = 1'b1;
                        state_nxt  = (GAP_CYCLES > 0) ? GAP : IDLE;
                    end else begin
                        state_nxt = STREAM;
                    end
                end
            end
            STREAM: begin
                if (cnt == LAST) begin
                    issue_over = 1'b1;
                    state_nxt  = (GAP_CYCLES > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (issue_over && !chain_end) begin
            infl_nxt = inflight + 4'd1;
        end else if (!issue_over && chain_end) begin
            if (inflight == 4'd0) begin
                spurious = 1'b1;
            end else begin
                infl_nxt = inflight - 4'd1;
            end
        end
        rdy_nxt = (state_nxt == STREAM) ||
                  ((state_nxt == IDLE) && (infl_nxt < MAX_CRED));
    end

    // Frame sequencer: sample slots, start/over pulses, gap timing, flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            gap_cnt      <= '0;
            s_ready      <= 1'b0;
            start        <= 1'b0;
            over         <= 1'b0;
            data_in_real <= '0;
            data_in_img  <= '0;
            busy         <= 1'b0;
            inflight     <= '0;
            err_underrun <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= infl_nxt;
            s_ready  <= rdy_nxt;
            busy     <= (state_nxt != IDLE) || (infl_nxt != 4'd0);
            start    <= 1'b0;
            over     <= issue_over;
            if (spurious) begin
                err_spurious <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    gap_cnt <= '0;
                    if (accept) begin
                        start        <= 1'b1;
                        data_in_real <= s_real;
                        data_in_img  <= s_img;
                        cnt          <= (N == 1) ? '0 : CW'(1);
                    end
                end
                STREAM: begin
                    gap_cnt <= '0;
                    cnt     <= cnt + CW'(1);
                    if (s_valid) begin
                        data_in_real <= s_real;
                        data_in_img  <= s_img;
                    end else begin
                        data_in_real <= '0;
                        data_in_img  <= '0;
                        err_underrun <= 1'b1;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + 8'd1;
                end
                default: begin
                    gap_cnt <= '0;
                end
            endcase
        end
    end

`ifdef FFT_FRAME_CNT_EN
    // Completed-frame counter; a clear request beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (cnt_clr) begin
            frame_cnt <= '0;
        end else if (over) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl: directed table-driven bench for fft_frame_ctrl.
// Frames are captured per output slot and compared against a vector table.
module tb_fft_frame_ctrl;

    localparam int N = 128;
    localparam int CAP = 210;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_real;
    logic [31:0] s_img;
    logic        start;
    logic        over;
    logic [31:0] data_in_real;
    logic [31:0] data_in_img;
    logic        chain_end;
    logic        busy;
    logic [3:0]  inflight;
    logic        err_underrun;
    logic        err_spurious;
`ifdef FFT_FRAME_CNT_EN
    logic        cnt_clr = 1'b0;
    logic [15:0] frame_cnt;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          frame;
        int          k;
        logic        st;
        logic        ov;
        logic [31:0] re;
        logic [31:0] im;
        logic [3:0]  infl;
    } vec_t;

    vec_t tbl[$];

    logic        obs_st [0:CAP-1];
    logic        obs_ov [0:CAP-1];
    logic        obs_rdy[0:CAP-1];
    logic [31:0] obs_re [0:CAP-1];
    logic [31:0] obs_im [0:CAP-1];
    logic [3:0]  obs_in [0:CAP-1];

    fft_frame_ctrl #(
        .LOG2N(7),
        .GAP_CYCLES(70),
        .MAX_INFLIGHT(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_real(s_real),
        .s_img(s_img),
        .start(start),
        .over(over),
        .data_in_real(data_in_real),
        .data_in_img(data_in_img),
        .chain_end(chain_end),
        .busy(busy),
        .inflight(inflight),
        .err_underrun(err_underrun),
        .err_spurious(err_spurious)
`ifdef FFT_FRAME_CNT_EN
        ,
        .cnt_clr(cnt_clr),
        .frame_cnt(frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(int f, int k, logic st, logic ov,
                                int re, int im, int infl);
        vec_t v;
        v.frame = f;
        v.k     = k;
        v.st    = st;
        v.ov    = ov;
        v.re    = 32'(re);
        v.im    = 32'(im);
        v.infl  = 4'(infl);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_s_ready"}, 32'(s_ready), 0);
        chk({tag, "_start"}, 32'(start), 0);
        chk({tag, "_over"}, 32'(over), 0);
        chk({tag, "_re"}, data_in_real, 0);
        chk({tag, "_im"}, data_in_img, 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_inflight"}, 32'(inflight), 0);
        chk({tag, "_err_u"}, 32'(err_underrun), 0);
        chk({tag, "_err_s"}, 32'(err_spurious), 0);
`ifdef FFT_FRAME_CNT_EN
        chk({tag, "_frame_cnt"}, 32'(frame_cnt), 0);
`endif
    endtask

    // Source frame k+j(-k); slots dlo..dhi are presented with s_valid low.
    task automatic run_frame(input int dlo, input int dhi, input int ce_at,
                             input int clr_at, input int ab_at,
                             output int waited);
        waited  = 0;
        s_valid = 1'b1;
        s_real  = 32'd0;
        s_img   = 32'd0;
        while (!s_ready && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (!s_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout act=0 exp=1");
            s_valid = 1'b0;
            return;
        end
        for (int k = 0; k < CAP; k++) begin
            @(negedge clk);
            obs_st[k]  = start;
            obs_ov[k]  = over;
            obs_rdy[k] = s_ready;
            obs_re[k]  = data_in_real;
            obs_im[k]  = data_in_img;
            obs_in[k]  = inflight;
            chain_end  = (k == ce_at);
`ifdef FFT_FRAME_CNT_EN
            cnt_clr = (k == clr_at);
`else
            if (clr_at > CAP) chain_end = 1'b0;
`endif
            if (k + 1 == ab_at) begin
                rst     = 1'b1;
                s_valid = 1'b0;
                return;
            end
            if (k + 1 < N) begin
                s_valid = !((k + 1 >= dlo) && (k + 1 <= dhi));
                s_real  = 32'(k + 1);
                s_img   = 32'(-(k + 1));
            end else begin
                s_valid = 1'b0;
            end
        end
    endtask

    task automatic check_frame(input int id);
        foreach (tbl[i]) begin
            if (tbl[i].frame == id) begin
                int k;
                k = tbl[i].k;
                checks++;
                if (obs_st[k] !== tbl[i].st || obs_ov[k] !== tbl[i].ov ||
                    obs_re[k] !== tbl[i].re || obs_im[k] !== tbl[i].im ||
                    obs_in[k] !== tbl[i].infl) begin
                    errors++;
                    $display("FAIL frame%0d_k%0d act st=%b ov=%b re=%0h im=%0h in=%0d exp st=%b ov=%b re=%0h im=%0h in=%0d",
                             id, k, obs_st[k], obs_ov[k], obs_re[k],
                             obs_im[k], obs_in[k], tbl[i].st, tbl[i].ov,
                             tbl[i].re, tbl[i].im, tbl[i].infl);
                end
            end
        end
    endtask

    task automatic retire();
        chain_end = 1'b1;
        @(negedge clk);
        chain_end = 1'b0;
    endtask

    initial begin
        int w;
        int cnt;
        logic ok;

        tbl.push_back(mk(1, 0,   1, 0, 0,   0,    0));
        tbl.push_back(mk(1, 1,   0, 0, 1,   -1,   0));
        tbl.push_back(mk(1, 64,  0, 0, 64,  -64,  0));
        tbl.push_back(mk(1, 126, 0, 0, 126, -126, 0));
        tbl.push_back(mk(1, 127, 0, 1, 127, -127, 1));
        tbl.push_back(mk(1, 128, 0, 0, 127, -127, 1));
        tbl.push_back(mk(2, 0,   1, 0, 0,   0,    1));
        tbl.push_back(mk(2, 9,   0, 0, 9,   -9,   1));
        tbl.push_back(mk(2, 10,  0, 0, 0,   0,    1));
        tbl.push_back(mk(2, 11,  0, 0, 0,   0,    1));
        tbl.push_back(mk(2, 12,  0, 0, 0,   0,    1));
        tbl.push_back(mk(2, 13,  0, 0, 13,  -13,  1));
        tbl.push_back(mk(2, 127, 0, 1, 127, -127, 2));
        tbl.push_back(mk(3, 0,   1, 0, 0,   0,    1));
        tbl.push_back(mk(3, 127, 0, 1, 127, -127, 1));
        tbl.push_back(mk(3, 128, 0, 0, 127, -127, 1));
        tbl.push_back(mk(5, 0,   1, 0, 0,   0,    0));
        tbl.push_back(mk(5, 60,  0, 0, 60,  -60,  0));
        tbl.push_back(mk(5, 127, 0, 1, 127, -127, 1));

        rst       = 1'b1;
        s_valid   = 1'b0;
        s_real    = '0;
        s_img     = '0;
        chain_end = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;

        // Plain frame, gap timing.
        run_frame(1000, -1, -1, -1, -1, w);
        check_frame(1);
        ok = 1'b1;
        for (int k = 127; k < 197; k++) begin
            if (obs_rdy[k] !== 1'b0) ok = 1'b0;
        end
        chk("gap_low", 32'(ok), 1);
        chk("gap_end", 32'(obs_rdy[197]), 1);
        chk("underrun_clean", 32'(err_underrun), 0);

        // Underrun in slots 10..12.
        run_frame(10, 12, -1, -1, -1, w);
        check_frame(2);
        chk("underrun_set", 32'(err_underrun), 1);

        // Credit exhausted: source waits with inflight at limit.
        s_valid = 1'b1;
        s_real  = '0;
        s_img   = '0;
        cnt = 0;
        repeat (250) begin
            @(negedge clk);
            if (s_ready) cnt++;
        end
        chk("credit_block", 32'(cnt), 0);
        chk("credit_infl", 32'(inflight), 2);
        chk("credit_busy", 32'(busy), 1);
        retire();
        chk("retire_infl", 32'(inflight), 1);
        chk("retire_ready", 32'(s_ready), 1);

        // Restart, with chain_end landing on the over slot.
        run_frame(1000, -1, 126, -1, -1, w);
        chk("restart_wait", 32'(w), 0);
        check_frame(3);
        chk("underrun_sticky", 32'(err_underrun), 1);

        // Drain, then a spurious chain_end.
        chain_end = 1'b1;
        @(negedge clk);
        chk("drain_infl", 32'(inflight), 0);
        chk("drain_spur", 32'(err_spurious), 0);
        @(negedge clk);
        chain_end = 1'b0;
        chk("spur_infl", 32'(inflight), 0);
        chk("spur_flag", 32'(err_spurious), 1);
        chk("idle_busy", 32'(busy), 0);

        // Reset mid-frame at sample 60.
        run_frame(1000, -1, -1, -1, 60, w);
        chk("abort_pre", obs_re[59], 59);
        @(negedge clk);
        check_reset("abort");
        rst = 1'b0;
        cnt = 0;
        repeat (140) begin
            @(negedge clk);
            if (over || start) cnt++;
        end
        chk("abort_no_pulse", 32'(cnt), 0);
        run_frame(1000, -1, -1, -1, -1, w);
        check_frame(5);

`ifdef FFT_FRAME_CNT_EN
        chk("fc_one", 32'(frame_cnt), 1);
        retire();
        run_frame(1000, -1, -1, -1, -1, w);
        retire();
        run_frame(1000, -1, -1, -1, -1, w);
        chk("fc_three", 32'(frame_cnt), 3);
        retire();
        run_frame(1000, -1, -1, 127, -1, w);
        chk("fc_clr", 32'(frame_cnt), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_frame_ctrl.md
Name: fft_frame_ctrl

Overview:
Front-end sequencer for the cascaded radix-2 SDF FFT chain (first stage fft_128, N=128). It accepts a valid/ready complex sample stream and registers it into the first stage, emitting the start pulse on sample 0 and the over pulse on sample N-1. It enforces an inter-frame gap and limits frames in flight using the end_next pulse returned from the last stage. Sticky error flags report underrun and protocol faults.

Parameters:
LOG2N, 7, log2 of frame length; N = 1<<LOG2N.
GAP_CYCLES, 70, minimum idle cycles between over of one frame and start of the next (6 + N/2 for N=128); legal range 0..255.
MAX_INFLIGHT, 2, maximum frames issued but not yet retired by chain_end; legal range 1..15.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  synchronous active-high reset.
s_valid  in  1  upstream sample valid.
s_ready  out  1  upstream ready; a sample is accepted when s_valid && s_ready.
s_real  in  32  sample real part.
s_img  in  32  sample imaginary part.
start  out  1  to first stage: high for exactly the cycle carrying sample 0.
over  out  1  to first stage: high for exactly the cycle carrying sample N-1.
data_in_real  out  32  to first stage, registered.
data_in_img  out  32  to first stage, registered.
chain_end  in  1  end_next pulse from the last FFT stage; one pulse retires one frame.
busy  out  1  high in any state except IDLE, or whenever inflight != 0.
inflight  out  4  number of frames in flight.
err_underrun  out  1  sticky; set when s_valid is low during STREAM.
err_spurious  out  1  sticky; set when chain_end arrives while inflight == 0.

Behaviour:
- Reset values: s_ready=0, start=0, over=0, data_in_*=0, busy=0, inflight=0, both error flags=0, FSM in IDLE, sample counter=0, gap counter=0.
- Reset mid-frame aborts the frame with no over pulse. Downstream stages share rst.
- FSM states and transitions:
  - IDLE: s_ready = (inflight < MAX_INFLIGHT). On acceptance, go to STREAM; outputs that sample with start=1 on the next cycle; sample counter = 1.
  - STREAM: s_ready=1.
    - Each cycle emits one sample with one-cycle latency from acceptance.
    - If s_valid=0, emit 0+j0 in that slot, set err_underrun, and still advance the counter. The frame is never stretched.
    - The slot with counter == N-1 carries over=1.
    - If N-1 == 0, start and over are asserted in the same cycle.
    - After the over slot: go to GAP if GAP_CYCLES > 0, else go to IDLE.
  - GAP: s_ready=0. Count GAP_CYCLES cycles, then go to IDLE.
- data_in_* hold their last value while no sample is issued. start and over are single-cycle pulses.
- Back-to-back: with GAP_CYCLES=0 and credit available, the start of frame k+1 can occur the cycle after the over of frame k.
- inflight:
  - +1 in the cycle over is issued; -1 on chain_end.
  - Both in the same cycle: unchanged.
  - chain_end at 0: stays 0 and sets err_spurious.
  - Never exceeds MAX_INFLIGHT by construction.
- Credit is checked only in IDLE. A frame that has started always completes.
- Error flags clear only on rst.
- Sample counter width is LOG2N bits and wraps to 0 after N-1.

Optional Feature:
FFT_FRAME_CNT_EN
- Defined: adds output frame_cnt (16 bits).
  - Reset 0; increments on each over pulse; wraps 65535 -> 0.
  - Also adds input cnt_clr (1 bit), which synchronously zeroes frame_cnt; cnt_clr wins over a simultaneous increment.
- Undefined: neither port exists and no counter logic is built.

Test Plan:
1. Reset, then 128 contiguous valid samples with value k+j(-k):
   - start high exactly at the first output cycle, with data_in_real=0.
   - over high 127 cycles later, with data_in_real=127 and data_in_img=-127.
   - inflight=1 the cycle after over.
   - s_ready low for 70 cycles after over.
2. s_valid dropped for cycles 10-12 of a frame:
   - Outputs 10-12 are 0+j0 and err_underrun=1.
   - over still arrives exactly 127 cycles after start; the flag persists until rst.
3. MAX_INFLIGHT=2, continuous source, no chain_end:
   - Two frames issue; s_ready stays low in IDLE with inflight=2.
   - One chain_end pulse produces inflight=1, and the next start follows after s_ready returns.
4. chain_end coincident with an over pulse at inflight=1: inflight stays 1. chain_end at inflight=0: err_spurious=1 and inflight stays 0.
5. rst asserted at sample 60:
   - The next cycle shows all outputs at reset values and no over.
   - A new frame then starts cleanly with start at sample 0.
6. With FFT_FRAME_CNT_EN defined:
   - 3 frames give frame_cnt=3.
   - cnt_clr in the same cycle as the 4th over gives frame_cnt=0.
